// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : acc_pkg
// Brief    : Shared accelerator widths, client ids and arbiter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package acc_pkg;

    localparam int ACC_ADDR_W = 32;
    localparam int ACC_DATA_W = 32;

    localparam int CLI_WEIGHT = 0;
    localparam int CLI_FEAT   = 1;
    localparam int CLI_OUT    = 2;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : arb_tag_fifo
// Brief    : Synchronous tag FIFO holding {client id, address} of issued reads.
// Revision : 1.0 - initial release
// ============================================================================
module arb_tag_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Storage needs no reset: empty gates every consumer of the head entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end
    end

    assign full     = (r_count == (PTR_W+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign pop_data = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/mem_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_rd_arb
// Brief    : Locking round-robin read arbiter with in-order tagged response routing.
// Revision : 1.0 - initial release
// ============================================================================
module mem_rd_arb
    import acc_pkg::*;
#(
    parameter int NUM_CLI = 3,
    parameter int ADDR_W  = ACC_ADDR_W,
    parameter int DATA_W  = ACC_DATA_W,
    parameter int OUTST   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CLI-1:0]        cli_req,
    input  logic [NUM_CLI-1:0]        cli_vld,
    input  logic [NUM_CLI*ADDR_W-1:0] cli_addr,
    output logic [NUM_CLI-1:0]        cli_rdy,
    output logic [ADDR_W-1:0]         rsp_addr,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [NUM_CLI-1:0]        rsp_vld,
    input  logic [NUM_CLI-1:0]        rsp_rdy,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_vld,
    input  logic                      mem_rdy,
    input  logic [DATA_W-1:0]         mem_rsp_data,
    input  logic                      mem_rsp_vld,
    output logic                      mem_rsp_rdy,
    output logic [NUM_CLI-1:0]        grant,
    output logic                      busy
);

    localparam int ID_W  = $clog2(NUM_CLI);
    localparam int TAG_W = ID_W + ADDR_W;

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic [NUM_CLI-1:0]   r_grant;
    logic [NUM_CLI-1:0]   w_grant_nxt;
    logic [ID_W-1:0]      r_last;
    logic [ID_W-1:0]      w_last_nxt;

    logic [2*NUM_CLI-1:0] w_req_dbl;
    logic [NUM_CLI-1:0]   w_req_rot;
    logic [ID_W:0]        w_off;
    logic [ID_W:0]        w_sum;
    logic                 w_sel_found;
    logic [ID_W-1:0]      w_sel_idx;

    logic [ADDR_W-1:0]    w_own_addr;
    logic                 w_fire;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic [TAG_W-1:0]     w_head;
    logic [ID_W-1:0]      w_head_id;
    logic [ADDR_W-1:0]    w_head_addr;

    // Rotate the request vector so bit 0 is the client just after last owner.
    always_comb begin
        w_req_dbl   = {cli_req, cli_req};
        w_req_rot   = NUM_CLI'(w_req_dbl >> ({1'b0, r_last} + 1'b1));
        w_sel_found = 1'b0;
        w_off       = '0;
        for (int i = NUM_CLI - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_sel_found = 1'b1;
                w_off       = (ID_W+1)'(i);
            end
        end
        w_sum = {1'b0, r_last} + w_off + 1'b1;
        if (w_sum >= (ID_W+1)'(NUM_CLI)) begin
            w_sum = w_sum - (ID_W+1)'(NUM_CLI);
        end
        w_sel_idx = ID_W'(w_sum);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            ARB_IDLE: begin
                if (w_sel_found) begin
                    w_state_nxt = ARB_LOCK;
                    w_grant_nxt = NUM_CLI'(1) << w_sel_idx;
                    w_last_nxt  = w_sel_idx;
                end
            end
            ARB_LOCK: begin
                if (!cli_req[r_last]) begin
                    w_state_nxt = ARB_IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_last  <= ID_W'(NUM_CLI - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_own_addr = '0;
        for (int i = 0; i < NUM_CLI; i++) begin
            if (r_grant[i]) begin
                w_own_addr = cli_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Full stalls issue outright; a same-cycle pop does not free a slot.
    assign mem_vld  = (|(r_grant & cli_req & cli_vld)) & ~w_full;
    assign w_fire   = mem_vld & mem_rdy;
    assign mem_addr = w_own_addr;
    assign cli_rdy  = r_grant & {NUM_CLI{w_fire}};
    assign grant    = r_grant;

    arb_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (OUTST)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_fire),
        .push_data ({r_last, w_own_addr}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign {w_head_id, w_head_addr} = w_head;

    always_comb begin
        rsp_vld = '0;
        if (mem_rsp_vld && !w_empty) begin
            rsp_vld = NUM_CLI'(1) << w_head_id;
        end
    end

    assign mem_rsp_rdy = ~w_empty & rsp_rdy[w_head_id];
    assign w_pop       = mem_rsp_vld & mem_rsp_rdy;
    assign rsp_addr    = w_empty ? '0 : w_head_addr;
    assign rsp_data    = mem_rsp_data;
    assign busy        = (|r_grant) | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_mem_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_rd_arb
// Brief    : Self-checking bench: vector table, directed sequences, random vs model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_rd_arb;
    import acc_pkg::*;

    localparam int N     = 3;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int OUTST = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    cli_req, cli_vld, cli_rdy, rsp_vld, rsp_rdy, grant;
    logic [N*AW-1:0] cli_addr;
    logic [AW-1:0]   rsp_addr, mem_addr;
    logic [DW-1:0]   rsp_data, mem_rsp_data;
    logic            mem_vld, mem_rdy, mem_rsp_vld, mem_rsp_rdy, busy;

    mem_rd_arb #(.NUM_CLI(N), .ADDR_W(AW), .DATA_W(DW), .OUTST(OUTST)) dut (
        .clk(clk), .rst_n(rst_n), .cli_req(cli_req), .cli_vld(cli_vld),
        .cli_addr(cli_addr), .cli_rdy(cli_rdy), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .mem_addr(mem_addr), .mem_vld(mem_vld), .mem_rdy(mem_rdy),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_vld(mem_rsp_vld),
        .mem_rsp_rdy(mem_rsp_rdy), .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: owner index (-1 = none), last owner, outstanding tags.
    typedef struct { int id; logic [AW-1:0] addr; } tag_t;
    tag_t m_q[$];
    int   m_owner = -1;
    int   m_last  = N - 1;

    // Memory and BIU emulation for the directed sequences.
    typedef struct { logic [AW-1:0] addr; int due; } mreq_t;
    mreq_t         emu_q[$];
    bit            emu_on  = 1'b0;
    int            emu_lat = 2;
    bit            biu_on  = 1'b0;
    int            beats   [N];
    logic [AW-1:0] baddr   [N];
    int            rdy_cnt [N];

    logic [N-1:0]  obs_grant, obs_rdy, obs_rsp_vld;
    logic          obs_mrr, obs_busy;
    logic [AW-1:0] obs_rsp_addr;
    logic [DW-1:0] obs_rsp_data;
    logic [N-1:0]  log_vld[$];
    logic [AW-1:0] log_addr[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        logic [N-1:0]  e_grant, e_rdy, e_rvld;
        logic          e_mvld, e_mrr, e_busy;
        logic [AW-1:0] e_maddr, e_raddr;
        e_grant = '0; e_rdy = '0; e_rvld = '0;
        e_mvld = 1'b0; e_mrr = 1'b0; e_busy = 1'b0;
        e_maddr = '0; e_raddr = '0;
        if (rst_n) begin
            if (m_owner >= 0) begin
                e_grant[m_owner] = 1'b1;
                e_maddr = cli_addr[m_owner*AW +: AW];
                e_mvld  = cli_req[m_owner] && cli_vld[m_owner] && (m_q.size() < OUTST);
                if (e_mvld && mem_rdy) e_rdy[m_owner] = 1'b1;
            end
            if (m_q.size() > 0) begin
                e_raddr = m_q[0].addr;
                e_mrr   = rsp_rdy[m_q[0].id];
                if (mem_rsp_vld) e_rvld[m_q[0].id] = 1'b1;
            end
            e_busy = (m_owner >= 0) || (m_q.size() > 0);
        end
        chk("grant", grant, e_grant);
        chk("cli_rdy", cli_rdy, e_rdy);
        chk("mem_vld", mem_vld, e_mvld);
        chk("mem_addr", mem_addr, e_maddr);
        chk("rsp_vld", rsp_vld, e_rvld);
        chk("rsp_addr", rsp_addr, e_raddr);
        chk("rsp_data", rsp_data, mem_rsp_data);
        chk("mem_rsp_rdy", mem_rsp_rdy, e_mrr);
        chk("busy", busy, e_busy);
    endtask

    task automatic model_advance();
        bit push, pop;
        int c;
        if (!rst_n) begin
            m_owner = -1; m_last = N - 1; m_q.delete();
            return;
        end
        pop  = (m_q.size() > 0) && mem_rsp_vld && rsp_rdy[m_q[0].id];
        push = (m_owner >= 0) && cli_req[m_owner] && cli_vld[m_owner] &&
               (m_q.size() < OUTST) && mem_rdy;
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back('{m_owner, cli_addr[m_owner*AW +: AW]});
        if (m_owner >= 0) begin
            if (!cli_req[m_owner]) m_owner = -1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (cli_req[c]) begin
                    m_owner = c; m_last = c;
                    break;
                end
            end
        end
    endtask

    task automatic drive_biu();
        for (int i = 0; i < N; i++) begin
            cli_req[i] = (beats[i] > 0);
            cli_vld[i] = (beats[i] > 0);
            cli_addr[i*AW +: AW] = baddr[i];
        end
    endtask

    task automatic drive_emu();
        if (emu_q.size() > 0 && emu_q[0].due <= cyc) begin
            mem_rsp_vld  = 1'b1;
            mem_rsp_data = emu_q[0].addr ^ 32'h5A5A_0000;
        end else begin
            mem_rsp_vld  = 1'b0;
            mem_rsp_data = '0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        obs_grant = grant; obs_rdy = cli_rdy; obs_rsp_vld = rsp_vld;
        obs_mrr = mem_rsp_rdy; obs_busy = busy;
        obs_rsp_addr = rsp_addr; obs_rsp_data = rsp_data;
        if (rsp_vld != '0 && mem_rsp_rdy) begin
            log_vld.push_back(rsp_vld);
            log_addr.push_back(rsp_addr);
        end
        for (int i = 0; i < N; i++) if (cli_rdy[i]) rdy_cnt[i]++;
        if (mem_vld && mem_rdy) emu_q.push_back('{mem_addr, cyc + emu_lat});
        if (emu_on && mem_rsp_vld && mem_rsp_rdy && emu_q.size() > 0) void'(emu_q.pop_front());
        if (biu_on) begin
            for (int i = 0; i < N; i++) begin
                if (cli_rdy[i]) begin
                    beats[i]--;
                    baddr[i] += 4;
                end
            end
        end
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
        if (biu_on) drive_biu();
        if (emu_on) drive_emu();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cli_req = '0; cli_vld = '0; cli_addr = '0;
        mem_rsp_vld = 1'b0; mem_rsp_data = '0;
        mem_rdy = 1'b1; rsp_rdy = '1;
        biu_on = 1'b0; emu_on = 1'b0;
        emu_q.delete(); log_vld.delete(); log_addr.delete();
        for (int i = 0; i < N; i++) begin
            beats[i] = 0; baddr[i] = '0; rdy_cnt[i] = 0;
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy === 1'b1 || cli_req != '0) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", n < budget, 1);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] vld;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_rdy;
    } vec_t;
    vec_t tbl [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N-1:0]  exp_v [4];
        logic [AW-1:0] exp_a [4];
        int            n;

        tbl[0]  = '{3'b101, 3'b000, 3'b000, 3'b000};
        tbl[1]  = '{3'b101, 3'b001, 3'b001, 3'b001};
        tbl[2]  = '{3'b101, 3'b001, 3'b001, 3'b001};
        tbl[3]  = '{3'b100, 3'b000, 3'b001, 3'b000};
        tbl[4]  = '{3'b100, 3'b000, 3'b000, 3'b000};
        tbl[5]  = '{3'b100, 3'b100, 3'b100, 3'b100};
        tbl[6]  = '{3'b000, 3'b000, 3'b100, 3'b000};
        tbl[7]  = '{3'b011, 3'b000, 3'b000, 3'b000};
        tbl[8]  = '{3'b010, 3'b010, 3'b001, 3'b000};
        tbl[9]  = '{3'b010, 3'b010, 3'b000, 3'b000};
        tbl[10] = '{3'b010, 3'b010, 3'b010, 3'b010};
        tbl[11] = '{3'b010, 3'b010, 3'b010, 3'b000};

        // Single client burst through a 2-cycle memory.
        do_reset();
        chk("reset_busy", obs_busy, 0);
        chk("reset_grant", obs_grant, 0);
        biu_on = 1'b1; emu_on = 1'b1; emu_lat = 2;
        beats[CLI_WEIGHT] = 8; baddr[CLI_WEIGHT] = 32'h1000;
        drive_biu();
        tick();
        chk("t1_grant_t", obs_grant, 3'b000);
        tick();
        chk("t1_grant_t1", obs_grant, 3'b001);
        chk("t1_rdy_t1", obs_rdy, 3'b001);
        wait_idle(200);
        chk("t1_rsp_count", log_vld.size(), 8);
        for (int k = 0; k < 8 && k < log_vld.size(); k++) begin
            chk("t1_rsp_vld", log_vld[k], 3'b001);
            chk("t1_rsp_addr", log_addr[k], 32'h1000 + 4 * k);
        end

        // Arbitration table: round-robin, lock, release latency, full stall.
        do_reset();
        for (int i = 0; i < N; i++) cli_addr[i*AW +: AW] = 32'h2000 + 32'h100 * i;
        for (int r = 0; r < 12; r++) begin
            cli_req = tbl[r].req;
            cli_vld = tbl[r].vld;
            tick();
            chk($sformatf("tbl%0d_grant", r), obs_grant, tbl[r].exp_grant);
            chk($sformatf("tbl%0d_rdy", r), obs_rdy, tbl[r].exp_rdy);
        end
        cli_req = '0; cli_vld = '0;
        exp_v = '{3'b001, 3'b001, 3'b100, 3'b010};
        exp_a = '{32'h2000, 32'h2000, 32'h2200, 32'h2100};
        for (int k = 0; k < 5; k++) begin
            mem_rsp_vld  = 1'b1;
            mem_rsp_data = $urandom;
            tick();
        end
        chk("drain_empty_rsp_vld", obs_rsp_vld, 3'b000);
        chk("drain_empty_mem_rsp_rdy", obs_mrr, 0);
        chk("drain_count", log_vld.size(), 4);
        for (int k = 0; k < 4 && k < log_vld.size(); k++) begin
            chk("drain_vld", log_vld[k], exp_v[k]);
            chk("drain_addr", log_addr[k], exp_a[k]);
        end

        // Outstanding limit with memory responses withheld.
        do_reset();
        biu_on = 1'b1;
        beats[CLI_WEIGHT] = 6; baddr[CLI_WEIGHT] = 32'h7000;
        drive_biu();
        repeat (12) tick();
        chk("full_rdy_pulses", rdy_cnt[CLI_WEIGHT], 4);
        chk("full_busy", obs_busy, 1);
        chk("full_rdy_stalled", obs_rdy, 3'b000);
        emu_on = 1'b1; emu_lat = 1;
        drive_emu();
        wait_idle(200);
        chk("full_total_rdy", rdy_cnt[CLI_WEIGHT], 6);
        chk("full_total_rsp", log_vld.size(), 6);

        // Owner hands over with beats still outstanding.
        do_reset();
        biu_on = 1'b1; emu_on = 1'b1; emu_lat = 8;
        beats[CLI_WEIGHT] = 3; baddr[CLI_WEIGHT] = 32'h3000;
        beats[CLI_FEAT]   = 3; baddr[CLI_FEAT]   = 32'h4000;
        drive_biu();
        wait_idle(300);
        chk("handover_count", log_vld.size(), 6);
        for (int k = 0; k < 6 && k < log_vld.size(); k++) begin
            chk("handover_vld", log_vld[k], (k < 3) ? 3'b001 : 3'b010);
            chk("handover_addr", log_addr[k], (k < 3) ? 32'h3000 + 4 * k : 32'h4000 + 4 * (k - 3));
        end

        // Response backpressure holds data and address.
        do_reset();
        rsp_rdy = '0;
        biu_on = 1'b1; emu_on = 1'b1; emu_lat = 2;
        beats[CLI_OUT] = 1; baddr[CLI_OUT] = 32'h5000;
        drive_biu();
        n = 0;
        while (mem_rsp_vld !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("bp_rsp_timeout", n < 20, 1);
        repeat (3) begin
            tick();
            chk("bp_mem_rsp_rdy", obs_mrr, 0);
            chk("bp_rsp_vld", obs_rsp_vld, 3'b100);
            chk("bp_rsp_addr", obs_rsp_addr, 32'h5000);
            chk("bp_rsp_data", obs_rsp_data, 32'h5A5A_5000);
        end
        rsp_rdy = '1;
        tick();
        chk("bp_accept", obs_mrr, 1);
        chk("bp_log", log_vld.size(), 1);
        wait_idle(50);

        // Asynchronous reset in the middle of a transfer.
        do_reset();
        biu_on = 1'b1; emu_on = 1'b1; emu_lat = 20;
        beats[CLI_WEIGHT] = 4; baddr[CLI_WEIGHT] = 32'h6000;
        drive_biu();
        n = 0;
        while (rdy_cnt[CLI_WEIGHT] < 2 && n < 20) begin
            tick();
            n++;
        end
        chk("rst_setup", rdy_cnt[CLI_WEIGHT], 2);
        #2;
        rst_n = 1'b0;
        mem_rsp_vld = 1'b1;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cli_rdy", cli_rdy, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_mem_vld", mem_vld, 0);
        chk("rst_mem_rsp_rdy", mem_rsp_rdy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        biu_on = 1'b0; emu_on = 1'b0; emu_q.delete();
        cli_req = '0; cli_vld = '0; mem_rsp_vld = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_fifo_empty", obs_busy, 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) cli_req[i] = ~cli_req[i];
                cli_addr[i*AW +: AW] = $urandom;
            end
            cli_vld      = N'($urandom);
            mem_rdy      = ($urandom_range(0, 3) != 0);
            mem_rsp_vld  = ($urandom_range(0, 1) == 1);
            mem_rsp_data = $urandom;
            rsp_rdy      = N'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
